// File: rtl/biss_c_slave.sv
// BiSS-C point-to-point slave: answers each MA burst with Ack, Start, CDS,
// position MSB-first, nError, nWarn and the inverted CRC6, then holds the timeout.
`timescale 1ns/1ps
module biss_c_slave #(
  parameter int SYNC_STAGES   = 2,
  parameter int ACK_CYCLES    = 1,
  parameter int TIMEOUT_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ma,
  output logic        slo,
  input  logic [31:0] position_in,
  input  logic [7:0]  resolution_bits,
  input  logic        error_n,
  input  logic        warn_n,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [3:0]  state_debug
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ACK     = 4'd1;
  localparam logic [3:0] S_START   = 4'd2;
  localparam logic [3:0] S_CDS     = 4'd3;
  localparam logic [3:0] S_DATA    = 4'd4;
  localparam logic [3:0] S_ERR     = 4'd5;
  localparam logic [3:0] S_WARN    = 4'd6;
  localparam logic [3:0] S_CRC     = 4'd7;
  localparam logic [3:0] S_TIMEOUT = 4'd8;

  localparam int            TW       = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [3:0]    ACK_N    = 4'(ACK_CYCLES);

  logic [SYNC_STAGES-1:0] ma_sync;
  logic                   ma_s;
  logic                   ma_prev;
  logic                   ma_rise;
  logic                   ma_fall;
  logic                   edge_any;

  logic [3:0]    state;
  logic [31:0]   pos_sh;
  logic [5:0]    n_lat;
  logic          err_lat;
  logic          warn_lat;
  logic [5:0]    crc;
  logic [3:0]    ack_cnt;
  logic [5:0]    bit_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_fire;
  logic [5:0]    n_clamp;
  logic [2:0]    crc_idx;

  // One MSB-first step of the x^6+x+1 LFSR.
  function automatic logic [5:0] crc_step(input logic [5:0] c, input logic b);
    logic fb;
    fb = c[5] ^ b;
    return {c[4:0], 1'b0} ^ {4'b0000, fb, fb};
  endfunction

  // The sync chain idles high so a reset never looks like a falling MA edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_sync <= '1;
      ma_prev <= 1'b1;
    end else begin
      ma_sync <= {ma_sync[SYNC_STAGES-2:0], ma};
      ma_prev <= ma_s;
    end
  end

  assign ma_s     = ma_sync[SYNC_STAGES-1];
  assign ma_rise  = ma_s & ~ma_prev;
  assign ma_fall  = ~ma_s & ma_prev;
  assign edge_any = ma_rise | ma_fall;

  always_comb begin
    n_clamp = resolution_bits[5:0];
    if (resolution_bits == 8'd0)
      n_clamp = 6'd1;
    else if (resolution_bits > 8'd32)
      n_clamp = 6'd32;
  end

  assign crc_idx  = 3'd5 - bit_cnt[2:0];
  // Fire one tick early so slo returns exactly TIMEOUT_TICKS after the edge is seen.
  assign tmo_fire = (state != S_IDLE) && !edge_any && ma_s && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      slo         <= 1'b1;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      pos_sh      <= '0;
      n_lat       <= '0;
      err_lat     <= 1'b1;
      warn_lat    <= 1'b1;
      crc         <= '0;
      ack_cnt     <= '0;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;

      if (state == S_IDLE || edge_any || tmo_fire)
        tmo_cnt <= '0;
      else if (ma_s)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (state == S_IDLE) begin
        slo <= 1'b1;
        if (ma_fall) begin
          // Left-align the position so every data bit leaves from pos_sh[31].
          pos_sh   <= position_in << (6'd32 - n_clamp);
          n_lat    <= n_clamp;
          err_lat  <= error_n;
          warn_lat <= warn_n;
          crc      <= '0;
          ack_cnt  <= '0;
          bit_cnt  <= '0;
          state    <= S_ACK;
        end
      end else if (tmo_fire) begin
        slo   <= 1'b1;
        state <= S_IDLE;
        if (state == S_TIMEOUT)
          frame_done <= 1'b1;
        else
          frame_abort <= 1'b1;
      end else if (ma_rise) begin
        case (state)
          S_ACK: begin
            if (ack_cnt < ACK_N) begin
              slo     <= 1'b0;
              ack_cnt <= ack_cnt + 1'b1;
            end else begin
              slo   <= 1'b1;
              state <= S_START;
            end
          end
          S_START: begin
            slo   <= 1'b0;
            state <= S_CDS;
          end
          S_CDS: begin
            slo     <= pos_sh[31];
            crc     <= crc_step(crc, pos_sh[31]);
            pos_sh  <= {pos_sh[30:0], 1'b0};
            bit_cnt <= 6'd1;
            state   <= S_DATA;
          end
          S_DATA: begin
            if (bit_cnt == n_lat) begin
              slo   <= err_lat;
              crc   <= crc_step(crc, err_lat);
              state <= S_ERR;
            end else begin
              slo     <= pos_sh[31];
              crc     <= crc_step(crc, pos_sh[31]);
              pos_sh  <= {pos_sh[30:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_ERR: begin
            slo   <= warn_lat;
            crc   <= crc_step(crc, warn_lat);
            state <= S_WARN;
          end
          S_WARN: begin
            slo     <= ~crc[5];
            bit_cnt <= 6'd1;
            state   <= S_CRC;
          end
          S_CRC: begin
            if (bit_cnt == 6'd6) begin
              slo   <= 1'b0;
              state <= S_TIMEOUT;
            end else begin
              slo     <= ~crc[crc_idx];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_TIMEOUT: slo <= 1'b0;
          default: begin
            slo   <= 1'b1;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign state_debug = state;

endmodule

// File: tb/tb_biss_c_slave.sv
// Bench for biss_c_slave: acts as the BiSS master, queues the expected slo bit for
// every MA fall and the expected end-of-frame pulse; monitors pop and compare.
`timescale 1ns/1ps
module tb_biss_c_slave;

  localparam int SYNC = 2;
  localparam int ACK  = 1;
  localparam int TMO  = 200;
  localparam int HALF = 250;

  logic        clk = 1'b0;
  logic        rst;
  logic        ma;
  logic        slo;
  logic [31:0] position_in;
  logic [7:0]  resolution_bits;
  logic        error_n;
  logic        warn_n;
  logic        busy;
  logic        frame_done;
  logic        frame_abort;
  logic [3:0]  state_debug;

  int errors = 0;
  int checks = 0;
  int frame_id = 0;

  typedef struct {
    bit chk;
    bit exp;
    int frame;
    int slot;
  } sb_t;

  sb_t sbq[$];
  int  evq[$];

  always #5 clk = ~clk;

  biss_c_slave #(
    .SYNC_STAGES(SYNC),
    .ACK_CYCLES(ACK),
    .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ma(ma),
    .slo(slo),
    .position_in(position_in),
    .resolution_bits(resolution_bits),
    .error_n(error_n),
    .warn_n(warn_n),
    .busy(busy),
    .frame_done(frame_done),
    .frame_abort(frame_abort),
    .state_debug(state_debug)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int clamp_n(input logic [7:0] rb);
    if (rb == 8'd0) return 1;
    if (rb > 8'd32) return 32;
    return int'(rb);
  endfunction

  function automatic logic [5:0] crc_model(input logic [31:0] pos, input int n, input logic e, input logic w);
    logic [5:0] c;
    logic       msb;
    c = 6'd0;
    for (int i = n + 1; i >= 0; i--) begin
      logic b;
      b = (i == 1) ? e : (i == 0) ? w : pos[i-2];
      msb = c[5];
      c = c << 1;
      if (msb != b) c = c ^ 6'b000011;
    end
    return c;
  endfunction

  // slo is read on every MA fall, exactly as the master samples it.
  always @(negedge ma) begin
    sb_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL slo sample: got %0b with no expected entry queued", slo);
    end else begin
      e = sbq.pop_front();
      if (e.chk)
        checkOutput($sformatf("slo frame%0d slot%0d", e.frame, e.slot), {31'b0, slo}, {31'b0, e.exp});
    end
  end

  // Frame-end pulses: code 1 = done, 2 = abort, 3 = both at once.
  always @(posedge clk) begin
    int code;
    #1;
    code = {30'b0, frame_abort, frame_done};
    if (code != 0) begin
      if (evq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL frame event: got code %0d, expected none", code);
      end else begin
        checkOutput("frame event", code, evq.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] pos, input logic [7:0] rb, input logic e,
                               input logic w, input int ncyc, input int chg_at, input int ev);
    int         n;
    logic [5:0] c;
    bit         eb[$];
    n = clamp_n(rb);
    frame_id++;
    position_in     = pos;
    resolution_bits = rb;
    error_n         = e;
    warn_n          = w;
    c = crc_model(pos, n, e, w);
    eb.push_back(1'b1);
    repeat (ACK) eb.push_back(1'b0);
    eb.push_back(1'b1);
    eb.push_back(1'b0);
    for (int i = n - 1; i >= 0; i--) eb.push_back(pos[i]);
    eb.push_back(e);
    eb.push_back(w);
    for (int i = 5; i >= 0; i--) eb.push_back(~c[i]);
    while (eb.size() < ncyc) eb.push_back(1'b0);
    if (ev != 0) evq.push_back(ev);
    @(posedge clk);
    #3;
    for (int i = 0; i < ncyc; i++) begin
      if (i == chg_at) begin
        position_in     = 32'h0;
        resolution_bits = 8'd8;
      end
      sbq.push_back('{1'b1, eb[i], frame_id, i});
      ma = 1'b0;
      #HALF;
      ma = 1'b1;
      if (i != ncyc - 1) #HALF;
    end
  endtask

  // Called right after the last MA rise of a burst.
  task automatic waitFrameEnd(input bit is_done, input string tag);
    int n;
    for (n = 1; n <= 3 * TMO; n++) begin
      @(posedge clk);
      #1;
      if (is_done ? (slo == 1'b1) : (busy == 1'b0)) break;
    end
    checkOutput({tag, " end latency"}, n, TMO + SYNC + 1);
    checkOutput({tag, " slo idle"}, {31'b0, slo}, 32'd1);
    checkOutput({tag, " state idle"}, {28'b0, state_debug}, 32'd0);
    checkOutput({tag, " busy low"}, {31'b0, busy}, 32'd0);
    repeat (20) @(posedge clk);
  endtask

  initial begin
    ma              = 1'b1;
    rst             = 1'b1;
    position_in     = 32'h0;
    resolution_bits = 8'd26;
    error_n         = 1'b1;
    warn_n          = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset slo", {31'b0, slo}, 32'd1);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset frame_done", {31'b0, frame_done}, 32'd0);
    checkOutput("reset frame_abort", {31'b0, frame_abort}, 32'd0);
    checkOutput("reset state", {28'b0, state_debug}, 32'd0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    $display("[TB] basic frame N=26");
    applyStimulus(32'h2AAAAAA, 8'd26, 1'b1, 1'b1, 40, -1, 1);
    waitFrameEnd(1'b1, "basic");

    $display("[TB] N=32 0xDEADBEEF");
    applyStimulus(32'hDEADBEEF, 8'd32, 1'b1, 1'b1, 32 + ACK + 13, -1, 1);
    waitFrameEnd(1'b1, "n32");

    $display("[TB] resolution 0 clamps to 1");
    applyStimulus(32'hDEADBEEF, 8'd0, 1'b1, 1'b1, 1 + ACK + 13, -1, 1);
    waitFrameEnd(1'b1, "n1");

    $display("[TB] resolution 40 clamps to 32");
    applyStimulus(32'h12345678, 8'd40, 1'b1, 1'b1, 32 + ACK + 13, -1, 1);
    waitFrameEnd(1'b1, "n40");

    $display("[TB] error and warning flags active");
    applyStimulus(32'h3FFFFFE, 8'd26, 1'b0, 1'b0, 40, -1, 1);
    waitFrameEnd(1'b1, "flags");

    $display("[TB] abort after 10th data bit");
    applyStimulus(32'h2AAAAAA, 8'd26, 1'b1, 1'b1, ACK + 13, -1, 2);
    waitFrameEnd(1'b0, "abort");
    applyStimulus(32'h1234567, 8'd26, 1'b1, 1'b1, 40, -1, 1);
    waitFrameEnd(1'b1, "after abort");

    $display("[TB] async reset mid-DATA");
    applyStimulus(32'h0, 8'd26, 1'b1, 1'b1, 12, -1, 0);
    #HALF;
    sbq.push_back('{1'b0, 1'b0, frame_id, 12});
    ma = 1'b0;
    #100;
    @(posedge clk);
    #2;
    checkOutput("slo before reset", {31'b0, slo}, 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("slo async reset", {31'b0, slo}, 32'd1);
    checkOutput("busy async reset", {31'b0, busy}, 32'd0);
    checkOutput("state async reset", {28'b0, state_debug}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      ma = 1'b1;
      #HALF;
      sbq.push_back('{1'b1, 1'b1, frame_id, 100 + i});
      ma = 1'b0;
      #HALF;
    end
    ma = 1'b1;
    #HALF;
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("idle after reset release", {31'b0, busy}, 32'd0);
    applyStimulus(32'h2AAAAAA, 8'd26, 1'b1, 1'b1, 40, -1, 1);
    waitFrameEnd(1'b1, "after reset");

    $display("[TB] inputs changed during DATA");
    applyStimulus(32'h3C3C3C3, 8'd26, 1'b1, 1'b0, 40, 8, 1);
    waitFrameEnd(1'b1, "latched");

    repeat (5) @(posedge clk);
    checkOutput("slo queue drained", sbq.size(), 32'd0);
    checkOutput("event queue drained", evq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2ms;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
